sik_fetch_stage: RTL and testbench

- Instruction-fetch stage of the dual-thread pipelined SIK stack processor; feeds the decode/stack stage directly downstream.
- Interleaves two hardware threads cycle by cycle and owns each thread's PC.
- Folds `pre` prefix instructions into the following instruction's 16-bit immediate.
- Accepts branch/call/return redirects from downstream.

---
 rtl/sik_pkg.sv | 35 +++
 rtl/sik_thread_ctx.sv | 61 ++++++
 rtl/sik_fetch_stage.sv | 124 ++++++++++++
 tb/tb_sik_fetch_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sik_pkg.sv
// Shared types and opcode constants for the SIK stack processor front end.
package sik_pkg;

  typedef logic [15:0] word_t;
  typedef logic [3:0]  opcode_t;
  typedef logic [11:0] immed12_t;
  typedef logic [3:0]  pre_t;

  // Normal opcodes occupy instr[15:12]; NOARG selects the extended
  // (operand-less) group, whose sub-opcode sits in the low bits.
  localparam opcode_t NOARG = 4'b0000;
  localparam opcode_t OPpre = 4'b1111;

  // Extended sub-opcodes (instr[3:0] when opcode == NOARG).
  localparam logic [3:0] XOP_NOP = 4'h0;
  localparam logic [3:0] XOP_RET = 4'h1;
  localparam logic [3:0] XOP_SYS = 4'hF;

  function automatic opcode_t opcode_of(input word_t instr);
    return instr[15:12];
  endfunction

  function automatic logic is_prefix(input word_t instr);
    return instr[15:12] == OPpre;
  endfunction

  // A pending prefix supplies the top nibble; otherwise sign-extend the
  // 12-bit field.
  function automatic word_t merge_immed(input logic pre_vld, input pre_t pre,
                                        input word_t instr);
    if (pre_vld) return {pre, instr[11:0]};
    return {{4{instr[11]}}, instr[11:0]};
  endfunction

endpackage

// File: rtl/sik_thread_ctx.sv
// Per-thread fetch context: PC plus the pending prefix nibble.
module sik_thread_ctx
  import sik_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  advance_i,
  input  logic  load_pre_i,
  input  logic  consume_i,
  input  pre_t  pre_i,
  input  logic  redirect_i,
  input  word_t redirect_pc_i,
  output word_t pc_o,
  output pre_t  pre_o,
  output logic  pre_vld_o
);

  word_t pc_q, pc_d;
  pre_t  pre_q, pre_d;
  logic  pre_vld_q, pre_vld_d;

  // Next-state: a redirect overrides any fetch activity of this thread.
  always_comb begin
    pc_d      = pc_q;
    pre_d     = pre_q;
    pre_vld_d = pre_vld_q;
    if (redirect_i) begin
      pc_d      = redirect_pc_i;
      pre_vld_d = 1'b0;
    end else if (advance_i) begin
      pc_d = pc_q + 16'd1;
      if (load_pre_i) begin
        pre_d     = pre_i;
        pre_vld_d = 1'b1;
      end else if (consume_i) begin
        pre_d     = '0;
        pre_vld_d = 1'b0;
      end
    end
  end

  // Context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pre_q     <= '0;
      pre_vld_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pre_q     <= pre_d;
      pre_vld_q <= pre_vld_d;
    end
  end

  assign pc_o      = pc_q;
  assign pre_o     = pre_q;
  assign pre_vld_o = pre_vld_q;

endmodule

// File: rtl/sik_fetch_stage.sv
// Dual-thread interleaved fetch stage with prefix folding and redirects.
module sik_fetch_stage
  import sik_pkg::*;
#(
  parameter word_t RESET_PC0 = 16'h0000,
  parameter word_t RESET_PC1 = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic [1:0]  halt_t,
  input  logic        redirect_valid,
  input  logic        redirect_tid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  output logic        out_tid,
  output logic [15:0] out_pc,
  output logic [15:0] out_instr,
  output logic [15:0] out_immed,
  output logic        out_has_pre
);

  logic  tsel_q, tsel_d;
  word_t pc0, pc1;
  pre_t  pre0, pre1;
  logic  pv0, pv1;

  logic  valid_q, valid_d;
  logic  tid_q, tid_d;
  word_t opc_q, opc_d;
  word_t instr_q, instr_d;
  word_t immed_q, immed_d;
  logic  has_pre_q, has_pre_d;

  word_t cur_pc;
  pre_t  cur_pre;
  logic  cur_pv;
  logic  slot_halted, slot_redir, fetch_go, slot_pre;
  logic  redir0, redir1, adv0, adv1;

  assign cur_pc      = tsel_q ? pc1  : pc0;
  assign cur_pre     = tsel_q ? pre1 : pre0;
  assign cur_pv      = tsel_q ? pv1  : pv0;
  assign imem_addr   = cur_pc;

  assign slot_halted = halt_t[tsel_q];
  assign slot_redir  = redirect_valid && (redirect_tid == tsel_q);
  assign fetch_go    = !stall && !slot_halted && !slot_redir;
  assign slot_pre    = is_prefix(imem_data);

  assign redir0 = redirect_valid && !redirect_tid;
  assign redir1 = redirect_valid &&  redirect_tid;
  assign adv0   = fetch_go && !tsel_q;
  assign adv1   = fetch_go &&  tsel_q;

  sik_thread_ctx #(.RESET_PC(RESET_PC0)) u_ctx0 (
    .clk(clk), .reset(reset),
    .advance_i(adv0), .load_pre_i(slot_pre), .consume_i(!slot_pre),
    .pre_i(imem_data[3:0]),
    .redirect_i(redir0), .redirect_pc_i(redirect_pc),
    .pc_o(pc0), .pre_o(pre0), .pre_vld_o(pv0)
  );

  sik_thread_ctx #(.RESET_PC(RESET_PC1)) u_ctx1 (
    .clk(clk), .reset(reset),
    .advance_i(adv1), .load_pre_i(slot_pre), .consume_i(!slot_pre),
    .pre_i(imem_data[3:0]),
    .redirect_i(redir1), .redirect_pc_i(redirect_pc),
    .pc_o(pc1), .pre_o(pre1), .pre_vld_o(pv1)
  );

  // Output register next-state: hold on stall (squash only), else load slot.
  always_comb begin
    tsel_d    = tsel_q;
    valid_d   = valid_q;
    tid_d     = tid_q;
    opc_d     = opc_q;
    instr_d   = instr_q;
    immed_d   = immed_q;
    has_pre_d = has_pre_q;
    if (stall) begin
      if (redirect_valid && (redirect_tid == tid_q)) valid_d = 1'b0;
    end else begin
      tsel_d    = !tsel_q;
      valid_d   = fetch_go && !slot_pre;
      tid_d     = tsel_q;
      opc_d     = cur_pc;
      instr_d   = imem_data;
      immed_d   = merge_immed(cur_pv, cur_pre, imem_data);
      has_pre_d = cur_pv;
    end
  end

  // Thread select and instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tsel_q    <= 1'b0;
      valid_q   <= 1'b0;
      tid_q     <= 1'b0;
      opc_q     <= '0;
      instr_q   <= '0;
      immed_q   <= '0;
      has_pre_q <= 1'b0;
    end else begin
      tsel_q    <= tsel_d;
      valid_q   <= valid_d;
      tid_q     <= tid_d;
      opc_q     <= opc_d;
      instr_q   <= instr_d;
      immed_q   <= immed_d;
      has_pre_q <= has_pre_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_tid     = tid_q;
  assign out_pc      = opc_q;
  assign out_instr   = instr_q;
  assign out_immed   = immed_q;
  assign out_has_pre = has_pre_q && valid_q;

endmodule

// File: tb/tb_sik_fetch_stage.sv
// Directed testbench for sik_fetch_stage.
module tb_sik_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic [1:0]  halt_t;
  logic        redirect_valid;
  logic        redirect_tid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_tid;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic [15:0] out_immed;
  logic        out_has_pre;

  logic [15:0] mem [0:65535];
  int checks   = 0;
  int failures = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  sik_fetch_stage #(.RESET_PC0(16'h0000), .RESET_PC1(16'h0001)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .halt_t(halt_t),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_tid(out_tid), .out_pc(out_pc),
    .out_instr(out_instr), .out_immed(out_immed), .out_has_pre(out_has_pre)
  );

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    stall          = 1'b0;
    halt_t         = 2'b00;
    redirect_valid = 1'b0;
    redirect_tid   = 1'b0;
    redirect_pc    = 16'h0000;
    step();
    reset = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic tid,
                           input logic [15:0] pc, input logic [15:0] immed,
                           input logic has_pre);
    check_val({tag, ".valid"}, 16'(out_valid), 16'h1);
    check_val({tag, ".tid"}, 16'(out_tid), 16'(tid));
    check_val({tag, ".pc"}, out_pc, pc);
    check_val({tag, ".immed"}, out_immed, immed);
    check_val({tag, ".has_pre"}, 16'(out_has_pre), 16'(has_pre));
  endtask

  initial begin
    // Basic interleave.
    clear_mem();
    mem[0] = 16'h8005;
    mem[1] = 16'h8007;
    do_reset();
    check_val("rst.valid", 16'(out_valid), 16'h0);
    check_val("rst.pc", out_pc, 16'h0000);
    check_val("rst.instr", out_instr, 16'h0000);
    check_val("rst.addr", imem_addr, 16'h0000);
    step();
    check_out("a1", 1'b0, 16'h0000, 16'h0005, 1'b0);
    check_val("a1.instr", out_instr, 16'h8005);
    check_val("a1.addr", imem_addr, 16'h0001);
    step();
    check_out("a2", 1'b1, 16'h0001, 16'h0007, 1'b0);

    // Prefix folding and pre-after-pre.
    clear_mem();
    mem[0] = 16'hF00A;
    mem[1] = 16'h1FFF;
    mem[2] = 16'hF003;
    mem[3] = 16'hF005;
    mem[4] = 16'h0123;
    do_reset();
    step();
    check_val("b1.valid", 16'(out_valid), 16'h0);
    step();
    check_out("b2", 1'b1, 16'h0001, 16'hFFFF, 1'b0);
    step();
    check_out("b3", 1'b0, 16'h0001, 16'hAFFF, 1'b1);
    step();
    check_val("b4.valid", 16'(out_valid), 16'h0);
    step();
    step();
    check_val("b6.valid", 16'(out_valid), 16'h0);
    step();
    step();
    check_out("b8", 1'b1, 16'h0004, 16'h5123, 1'b1);

    // Redirect of the current slot, sign extension, PC wrap.
    clear_mem();
    mem[16'hFFFF] = 16'h1800;
    do_reset();
    redirect_valid = 1'b1;
    redirect_tid   = 1'b0;
    redirect_pc    = 16'hFFFF;
    step();
    check_val("c1.valid", 16'(out_valid), 16'h0);
    redirect_valid = 1'b0;
    step();
    check_out("c2", 1'b1, 16'h0001, 16'h0000, 1'b0);
    step();
    check_out("c3", 1'b0, 16'hFFFF, 16'hF800, 1'b0);
    step();
    check_val("c4.addr", imem_addr, 16'h0000);
    step();
    check_out("c5", 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Stall hold and resume.
    clear_mem();
    mem[0] = 16'h8005;
    mem[1] = 16'h8007;
    do_reset();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("d.stall", 1'b0, 16'h0000, 16'h0005, 1'b0);
      check_val("d.stall.addr", imem_addr, 16'h0001);
    end
    stall = 1'b0;
    step();
    check_out("d.res1", 1'b1, 16'h0001, 16'h0007, 1'b0);
    step();
    check_out("d.res2", 1'b0, 16'h0001, 16'h0007, 1'b0);

    // Redirect with pending prefix, then squash during stall.
    clear_mem();
    mem[0]     = 16'hF00C;
    mem[1]     = 16'h2001;
    mem[16'h40] = 16'h3005;
    mem[16'h50] = 16'h4002;
    mem[16'h60] = 16'h5003;
    do_reset();
    step();
    check_val("e1.valid", 16'(out_valid), 16'h0);
    redirect_valid = 1'b1;
    redirect_tid   = 1'b0;
    redirect_pc    = 16'h0040;
    step();
    check_out("e2", 1'b1, 16'h0001, 16'h0001, 1'b0);
    redirect_valid = 1'b0;
    step();
    check_out("e3", 1'b0, 16'h0040, 16'h0005, 1'b0);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_tid   = 1'b1;
    redirect_pc    = 16'h0050;
    step();
    check_out("e4", 1'b0, 16'h0040, 16'h0005, 1'b0);
    check_val("e4.addr", imem_addr, 16'h0050);
    redirect_tid = 1'b0;
    redirect_pc  = 16'h0060;
    step();
    check_val("e5.squash", 16'(out_valid), 16'h0);
    check_val("e5.pc", out_pc, 16'h0040);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    step();
    check_out("e6", 1'b1, 16'h0050, 16'h0002, 1'b0);
    step();
    check_out("e7", 1'b0, 16'h0060, 16'h0003, 1'b0);

    // Halted thread 1, then asynchronous reset mid-stream.
    clear_mem();
    mem[0] = 16'h8005;
    mem[1] = 16'h8007;
    mem[2] = 16'h8009;
    do_reset();
    halt_t = 2'b10;
    step();
    check_out("f1", 1'b0, 16'h0000, 16'h0005, 1'b0);
    step();
    check_val("f2.valid", 16'(out_valid), 16'h0);
    step();
    check_out("f3", 1'b0, 16'h0001, 16'h0007, 1'b0);
    check_val("f3.addr", imem_addr, 16'h0001);
    step();
    check_val("f4.valid", 16'(out_valid), 16'h0);
    check_val("f4.addr", imem_addr, 16'h0002);
    step();
    check_out("f5", 1'b0, 16'h0002, 16'h0009, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_val("g.valid", 16'(out_valid), 16'h0);
    check_val("g.pc", out_pc, 16'h0000);
    check_val("g.instr", out_instr, 16'h0000);
    check_val("g.immed", out_immed, 16'h0000);
    check_val("g.addr", imem_addr, 16'h0000);
    step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
